trap_sequencer: RTL and testbench

- Machine-mode trap controller that sequences the CSR file's hardware-update path on an in-order single-issue core.
- Sits between the commit stage and the CSR file. It detects synchronous exceptions, gated interrupts and mret at instruction commit, and drains outstanding memory traffic.
- It pulses the CSR file's exception/mret strobes with mepc/mcause hardware data, then issues a redirect to fetch with a valid/ready handshake.

---
 rtl/trap_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_trap_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// ---------------------------------------------------------------------------
// trap_sequencer
//
// Machine-mode trap controller for an in-order single-issue core. It sits
// between the commit stage and the CSR file. It runs these steps in order:
//   1. Capture a synchronous exception, gated interrupt or mret at commit.
//   2. Wait for outstanding memory traffic to drain.
//   3. Pulse the CSR file's exception or mret strobe for one cycle.
//   4. Hand the new fetch PC to the front end with a valid/ready handshake.
//
// Ports
//   clk, rst                core clock, asynchronous active-low reset
//   commit_*                committing instruction: valid, ready, pc, npc
//   illegal_i/ebreak_i/ecall_i/mret_i
//                           event flags of the committing instruction
//   eirp_i, tirp_i          external / timer interrupt (already gated)
//   lsu_busy_i              memory unit still has a transaction in flight
//   csr_mtvec_i, csr_mepc_i current trap vector and exception PC
//   csr_exception_o         one-cycle strobe with mepc/mcause hardware data
//   csr_mret_o              one-cycle strobe for the mstatus restore
//   csr_mepc_hwdata_o       mepc value sent with the exception strobe
//   csr_mcause_hwdata_o     mcause value sent with the exception strobe
//   flush_o                 kill younger in-flight instructions
//   redirect_valid_o/_ready_i/_pc_o
//                           handshake that sends the new fetch PC
// ---------------------------------------------------------------------------
module trap_sequencer #(
  parameter int DATA_WIDTH  = 64,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  commit_valid_i,
  output logic                  commit_ready_o,
  input  logic [DATA_WIDTH-1:0] commit_pc_i,
  input  logic [DATA_WIDTH-1:0] commit_npc_i,
  input  logic                  illegal_i,
  input  logic                  ebreak_i,
  input  logic                  ecall_i,
  input  logic                  mret_i,
  input  logic                  eirp_i,
  input  logic                  tirp_i,
  input  logic                  lsu_busy_i,
  input  logic [DATA_WIDTH-1:0] csr_mtvec_i,
  input  logic [DATA_WIDTH-1:0] csr_mepc_i,
  output logic                  csr_exception_o,
  output logic                  csr_mret_o,
  output logic [DATA_WIDTH-1:0] csr_mepc_hwdata_o,
  output logic [DATA_WIDTH-1:0] csr_mcause_hwdata_o,
  output logic                  flush_o,
  output logic                  redirect_valid_o,
  input  logic                  redirect_ready_i,
  output logic [DATA_WIDTH-1:0] redirect_pc_o
);

  localparam int DW = DATA_WIDTH;

  localparam logic [DW-1:0] IRQ_BIT       = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] CAUSE_ILLEGAL = DW'(2);
  localparam logic [DW-1:0] CAUSE_EBREAK  = DW'(3);
  localparam logic [DW-1:0] CAUSE_ECALL   = DW'(11);
  localparam logic [DW-1:0] CAUSE_MEI     = IRQ_BIT | DW'(11);
  localparam logic [DW-1:0] CAUSE_MTI     = IRQ_BIT | DW'(7);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_COMMIT,
    S_REDIRECT
  } state_e;

  typedef enum logic [1:0] {
    K_NONE,
    K_EXC,
    K_IRQ,
    K_MRET
  } kind_e;

  state_e          state_q, state_d;
  kind_e           kind_q, kind_d;
  logic [DW-1:0]   cause_q, cause_d;
  logic [DW-1:0]   epc_q, epc_d;
  logic [DW-1:0]   redirect_pc_q, redirect_pc_d;
  logic            flush_q, flush_d;

  logic [DW-1:0]   trap_base;
  logic [DW-1:0]   vector_offset;
  logic [DW-1:0]   target_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      kind_q        <= K_NONE;
      cause_q       <= '0;
      epc_q         <= '0;
      redirect_pc_q <= '0;
      flush_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      cause_q       <= cause_d;
      epc_q         <= epc_d;
      redirect_pc_q <= redirect_pc_d;
      flush_q       <= flush_d;
    end
  end

  // In vectored mode the vector offset is 4*cause with the interrupt bit
  // dropped. That equals the low cause bits shifted left by two and
  // truncated to DW bits, so the add wraps modulo 2^DW.
  always_comb begin
    trap_base     = {csr_mtvec_i[DW-1:2], 2'b00};
    vector_offset = {cause_q[DW-3:0], 2'b00};
    if (kind_q == K_MRET) begin
      target_pc = csr_mepc_i;
    end else if (VECTORED_EN && (kind_q == K_IRQ) && (csr_mtvec_i[1:0] == 2'b01)) begin
      target_pc = trap_base + vector_offset;
    end else begin
      target_pc = trap_base;
    end
  end

  // Synchronous exceptions beat mret, and mret beats interrupts. An
  // interrupt that is pending on an mret commit therefore waits for a
  // later commit. Interrupts are only looked at while a commit is present.
  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    cause_d       = cause_q;
    epc_d         = epc_q;
    redirect_pc_d = redirect_pc_q;

    unique case (state_q)
      S_IDLE: begin
        if (commit_valid_i) begin
          if (illegal_i || ebreak_i || ecall_i) begin
            kind_d  = K_EXC;
            epc_d   = commit_pc_i;
            state_d = S_DRAIN;
            if (illegal_i) begin
              cause_d = CAUSE_ILLEGAL;
            end else if (ebreak_i) begin
              cause_d = CAUSE_EBREAK;
            end else begin
              cause_d = CAUSE_ECALL;
            end
          end else if (mret_i) begin
            kind_d  = K_MRET;
            cause_d = '0;
            epc_d   = '0;
            state_d = S_DRAIN;
          end else if (eirp_i || tirp_i) begin
            kind_d  = K_IRQ;
            epc_d   = commit_npc_i;
            cause_d = eirp_i ? CAUSE_MEI : CAUSE_MTI;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!lsu_busy_i) begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        // The redirect target is frozen here, so later changes to mtvec
        // or mepc cannot disturb a pending redirect.
        redirect_pc_d = target_pc;
        state_d       = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (redirect_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    flush_d = (state_d != S_IDLE);
  end

  always_comb begin
    commit_ready_o      = (state_q == S_IDLE);
    flush_o             = flush_q;
    csr_exception_o     = 1'b0;
    csr_mret_o          = 1'b0;
    csr_mepc_hwdata_o   = '0;
    csr_mcause_hwdata_o = '0;
    redirect_valid_o    = 1'b0;
    redirect_pc_o       = '0;

    if (state_q == S_COMMIT) begin
      if (kind_q == K_MRET) begin
        csr_mret_o = 1'b1;
      end else begin
        csr_exception_o     = 1'b1;
        csr_mepc_hwdata_o   = epc_q;
        csr_mcause_hwdata_o = cause_q;
      end
    end

    if (state_q == S_REDIRECT) begin
      redirect_valid_o = 1'b1;
      redirect_pc_o    = redirect_pc_q;
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// ---------------------------------------------------------------------------
// tb_trap_sequencer
//
// Two instances run side by side on shared stimulus. One has vectored
// interrupts enabled and the other always uses direct mode. Directed table
// vectors, hand-written corner sequences and randomized transactions are
// all compared against expectations that the bench computes itself.
// ---------------------------------------------------------------------------
module tb_trap_sequencer;

  localparam int DW = 64;
  localparam logic [DW-1:0] IRQ = 64'h8000_0000_0000_0000;

  localparam int K_NONE = 0;
  localparam int K_EXC  = 1;
  localparam int K_MRET = 2;
  localparam int K_IRQ  = 3;

  typedef struct packed {
    logic          ready;
    logic          exc;
    logic          mret;
    logic          flush;
    logic          rv;
    logic [DW-1:0] mepc;
    logic [DW-1:0] mcause;
    logic [DW-1:0] rpc;
  } outs_t;

  typedef struct {
    logic          cv, ill, ebr, ecl, mrt, eirp, tirp;
    logic [DW-1:0] pc, npc, mtvec, mepc;
    int            kind;
    logic [DW-1:0] cause, epc, rpc_v, rpc_d;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          commit_valid, illegal, ebreak, ecall, mret, eirp, tirp;
  logic          lsu_busy, redirect_ready;
  logic [DW-1:0] commit_pc, commit_npc, csr_mtvec, csr_mepc;

  logic          ready_v, exc_v, mret_v, flush_v, rv_v;
  logic [DW-1:0] mepc_v, mcause_v, rpc_v;
  logic          ready_d, exc_d, mret_d, flush_d, rv_d;
  logic [DW-1:0] mepc_d, mcause_d, rpc_d;

  int checks = 0;
  int errors = 0;

  trap_sequencer #(.DATA_WIDTH(DW), .VECTORED_EN(1'b1)) dut_v (
    .clk(clk), .rst(rst),
    .commit_valid_i(commit_valid), .commit_ready_o(ready_v),
    .commit_pc_i(commit_pc), .commit_npc_i(commit_npc),
    .illegal_i(illegal), .ebreak_i(ebreak), .ecall_i(ecall), .mret_i(mret),
    .eirp_i(eirp), .tirp_i(tirp), .lsu_busy_i(lsu_busy),
    .csr_mtvec_i(csr_mtvec), .csr_mepc_i(csr_mepc),
    .csr_exception_o(exc_v), .csr_mret_o(mret_v),
    .csr_mepc_hwdata_o(mepc_v), .csr_mcause_hwdata_o(mcause_v),
    .flush_o(flush_v), .redirect_valid_o(rv_v),
    .redirect_ready_i(redirect_ready), .redirect_pc_o(rpc_v)
  );

  trap_sequencer #(.DATA_WIDTH(DW), .VECTORED_EN(1'b0)) dut_d (
    .clk(clk), .rst(rst),
    .commit_valid_i(commit_valid), .commit_ready_o(ready_d),
    .commit_pc_i(commit_pc), .commit_npc_i(commit_npc),
    .illegal_i(illegal), .ebreak_i(ebreak), .ecall_i(ecall), .mret_i(mret),
    .eirp_i(eirp), .tirp_i(tirp), .lsu_busy_i(lsu_busy),
    .csr_mtvec_i(csr_mtvec), .csr_mepc_i(csr_mepc),
    .csr_exception_o(exc_d), .csr_mret_o(mret_d),
    .csr_mepc_hwdata_o(mepc_d), .csr_mcause_hwdata_o(mcause_d),
    .flush_o(flush_d), .redirect_valid_o(rv_d),
    .redirect_ready_i(redirect_ready), .redirect_pc_o(rpc_d)
  );

  // Hard stop in case the sequence ever stops advancing.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic outs_t mk(logic r, logic e, logic m, logic f, logic v,
                               logic [DW-1:0] a, logic [DW-1:0] b, logic [DW-1:0] c);
    outs_t o;
    o.ready = r; o.exc = e; o.mret = m; o.flush = f; o.rv = v;
    o.mepc = a; o.mcause = b; o.rpc = c;
    return o;
  endfunction

  function automatic vec_t mkvec(logic cv, logic ill, logic ebr, logic ecl, logic mrt,
                                 logic ei, logic ti, logic [DW-1:0] pc, logic [DW-1:0] npc,
                                 logic [DW-1:0] mtvec, logic [DW-1:0] mepc, int kind,
                                 logic [DW-1:0] cause, logic [DW-1:0] epc,
                                 logic [DW-1:0] rv, logic [DW-1:0] rd);
    vec_t t;
    t.cv = cv; t.ill = ill; t.ebr = ebr; t.ecl = ecl; t.mrt = mrt; t.eirp = ei; t.tirp = ti;
    t.pc = pc; t.npc = npc; t.mtvec = mtvec; t.mepc = mepc;
    t.kind = kind; t.cause = cause; t.epc = epc; t.rpc_v = rv; t.rpc_d = rd;
    return t;
  endfunction

  // Reference model: derives the trap outcome from the architectural
  // rules with plain arithmetic on the commit record.
  function automatic vec_t predict(vec_t t);
    vec_t          r = t;
    logic [DW-1:0] base;
    base = t.mtvec - (t.mtvec % 4);
    r.kind = K_NONE; r.cause = '0; r.epc = '0; r.rpc_v = '0; r.rpc_d = '0;
    if (t.cv) begin
      if (t.ill || t.ebr || t.ecl) begin
        r.kind  = K_EXC;
        r.cause = t.ill ? 64'd2 : (t.ebr ? 64'd3 : 64'd11);
        r.epc   = t.pc;
        r.rpc_v = base;
        r.rpc_d = base;
      end else if (t.mrt) begin
        r.kind  = K_MRET;
        r.rpc_v = t.mepc;
        r.rpc_d = t.mepc;
      end else if (t.eirp || t.tirp) begin
        r.kind  = K_IRQ;
        r.cause = IRQ + (t.eirp ? 64'd11 : 64'd7);
        r.epc   = t.npc;
        r.rpc_d = base;
        if (t.mtvec % 4 == 1) r.rpc_v = base + 4 * (t.eirp ? 64'd11 : 64'd7);
        else                  r.rpc_v = base;
      end
    end
    return r;
  endfunction

  task automatic compareOne(string name, string which, outs_t act, outs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (%s) got rdy=%b exc=%b mret=%b flush=%b rv=%b mepc=%h mcause=%h rpc=%h, need rdy=%b exc=%b mret=%b flush=%b rv=%b mepc=%h mcause=%h rpc=%h",
               name, which, act.ready, act.exc, act.mret, act.flush, act.rv, act.mepc, act.mcause, act.rpc,
               exp.ready, exp.exc, exp.mret, exp.flush, exp.rv, exp.mepc, exp.mcause, exp.rpc);
    end
  endtask

  task automatic checkOutput(string name, outs_t exp, logic [DW-1:0] rpc_direct);
    outs_t exp_d;
    exp_d     = exp;
    exp_d.rpc = rpc_direct;
    compareOne(name, "vectored", mk(ready_v, exc_v, mret_v, flush_v, rv_v, mepc_v, mcause_v, rpc_v), exp);
    compareOne(name, "direct", mk(ready_d, exc_d, mret_d, flush_d, rv_d, mepc_d, mcause_d, rpc_d), exp_d);
  endtask

  task automatic driveCommit(vec_t t);
    commit_valid = t.cv; illegal = t.ill; ebreak = t.ebr; ecall = t.ecl;
    mret = t.mrt; eirp = t.eirp; tirp = t.tirp;
    commit_pc = t.pc; commit_npc = t.npc; csr_mtvec = t.mtvec; csr_mepc = t.mepc;
  endtask

  task automatic driveJunk();
    commit_valid = 1'b1;
    illegal = $urandom % 2 == 0; ebreak = $urandom % 2 == 0; ecall = $urandom % 2 == 0;
    mret = $urandom % 2 == 0; eirp = $urandom % 2 == 0; tirp = $urandom % 2 == 0;
    commit_pc = {$urandom, $urandom}; commit_npc = {$urandom, $urandom};
    csr_mtvec = {$urandom, $urandom}; csr_mepc = {$urandom, $urandom};
  endtask

  // One commit plus the whole trap sequence that follows it: `drain` cycles
  // of lsu_busy and `bp` cycles of redirect backpressure. With junk set the
  // ignored inputs are scrambled while the sequencer is busy.
  task automatic applyStimulus(string name, vec_t t, int drain, int bp, bit junk);
    driveCommit(t);
    lsu_busy       = 1'b0;
    redirect_ready = junk ? 1'($urandom % 2) : 1'b0;
    checkOutput({name, ":idle"}, mk(1, 0, 0, 0, 0, '0, '0, '0), '0);
    tick();
    if (t.kind == K_NONE) return;

    for (int i = 0; i <= drain; i++) begin
      if (junk) driveJunk();
      lsu_busy = (i < drain);
      checkOutput({name, ":drain"}, mk(0, 0, 0, 1, 0, '0, '0, '0), '0);
      tick();
    end

    if (junk) driveJunk();
    csr_mtvec = t.mtvec;
    csr_mepc  = t.mepc;
    lsu_busy  = junk ? 1'($urandom % 2) : 1'b0;
    if (t.kind == K_MRET)
      checkOutput({name, ":strobe"}, mk(0, 0, 1, 1, 0, '0, '0, '0), '0);
    else
      checkOutput({name, ":strobe"}, mk(0, 1, 0, 1, 0, t.epc, t.cause, '0), '0);
    tick();

    for (int i = 0; i <= bp; i++) begin
      if (junk) driveJunk();
      redirect_ready = (i == bp);
      checkOutput({name, ":redirect"}, mk(0, 0, 0, 1, 1, '0, '0, t.rpc_v), t.rpc_d);
      tick();
    end
    redirect_ready = 1'b0;
    lsu_busy       = 1'b0;
  endtask

  vec_t table_v[11];
  vec_t seq_v;

  initial begin
    // Directed vectors: commit record and the outcome it must produce.
    table_v[0]  = mkvec(1,0,0,1,0,0,0, 64'h8000_0010, 64'h8000_0014, 64'h8000_0100, 64'h0,
                        K_EXC, 64'd11, 64'h8000_0010, 64'h8000_0100, 64'h8000_0100);
    table_v[1]  = mkvec(1,0,0,0,0,1,0, 64'h8000_0200, 64'h8000_0204, 64'h8000_0101, 64'h0,
                        K_IRQ, 64'h8000_0000_0000_000B, 64'h8000_0204, 64'h8000_012C, 64'h8000_0100);
    table_v[2]  = mkvec(1,0,0,0,0,0,1, 64'h8000_0200, 64'h8000_0204, 64'h8000_0101, 64'h0,
                        K_IRQ, 64'h8000_0000_0000_0007, 64'h8000_0204, 64'h8000_011C, 64'h8000_0100);
    table_v[3]  = mkvec(1,1,1,1,0,1,0, 64'h1000, 64'h1004, 64'h8000_0101, 64'h0,
                        K_EXC, 64'd2, 64'h1000, 64'h8000_0100, 64'h8000_0100);
    table_v[4]  = mkvec(1,0,1,1,0,0,0, 64'h2000, 64'h2004, 64'h8000_0100, 64'h0,
                        K_EXC, 64'd3, 64'h2000, 64'h8000_0100, 64'h8000_0100);
    table_v[5]  = mkvec(1,0,0,1,1,0,0, 64'h3000, 64'h3004, 64'h4000_0000, 64'h5555,
                        K_EXC, 64'd11, 64'h3000, 64'h4000_0000, 64'h4000_0000);
    table_v[6]  = mkvec(1,0,0,0,1,0,1, 64'h3100, 64'h3104, 64'h8000_0101, 64'h8000_0040,
                        K_MRET, 64'h0, 64'h0, 64'h8000_0040, 64'h8000_0040);
    table_v[7]  = mkvec(1,0,0,0,0,0,0, 64'h3200, 64'h3204, 64'h8000_0100, 64'h0,
                        K_NONE, 64'h0, 64'h0, 64'h0, 64'h0);
    table_v[8]  = mkvec(0,1,0,0,0,1,0, 64'h3300, 64'h3304, 64'h8000_0100, 64'h0,
                        K_NONE, 64'h0, 64'h0, 64'h0, 64'h0);
    table_v[9]  = mkvec(1,0,0,0,0,1,1, 64'h10, 64'h20, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0,
                        K_IRQ, 64'h8000_0000_0000_000B, 64'h20, 64'h28, 64'hFFFF_FFFF_FFFF_FFFC);
    table_v[10] = mkvec(1,0,0,0,0,1,0, 64'h40, 64'h44, 64'h8000_0103, 64'h0,
                        K_IRQ, 64'h8000_0000_0000_000B, 64'h44, 64'h8000_0100, 64'h8000_0100);

    rst = 1'b0;
    commit_valid = 0; illegal = 0; ebreak = 0; ecall = 0; mret = 0; eirp = 0; tirp = 0;
    lsu_busy = 0; redirect_ready = 0;
    commit_pc = '0; commit_npc = '0; csr_mtvec = '0; csr_mepc = '0;
    tick();
    tick();
    checkOutput("reset", mk(1, 0, 0, 0, 0, '0, '0, '0), '0);
    rst = 1'b1;
    tick();

    $display("[TB] directed table");
    for (int i = 0; i < 11; i++) begin
      applyStimulus($sformatf("table%0d", i), table_v[i], 0, 0, 1'b0);
    end

    $display("[TB] drain held three cycles");
    seq_v = mkvec(1,1,0,1,0,0,0, 64'h5000, 64'h5004, 64'h8000_0100, 64'h0,
                  K_EXC, 64'd2, 64'h5000, 64'h8000_0100, 64'h8000_0100);
    applyStimulus("drain3", seq_v, 3, 0, 1'b0);

    $display("[TB] mret defers pending interrupt");
    seq_v = mkvec(1,0,0,0,1,1,0, 64'h6000, 64'h6004, 64'h8000_0100, 64'h8000_0040,
                  K_MRET, 64'h0, 64'h0, 64'h8000_0040, 64'h8000_0040);
    applyStimulus("mret_eirp", seq_v, 0, 0, 1'b0);
    seq_v = mkvec(0,0,0,0,0,1,0, 64'h8000_02FC, 64'h8000_0300, 64'h8000_0100, 64'h0,
                  K_NONE, 64'h0, 64'h0, 64'h0, 64'h0);
    applyStimulus("irq_no_commit", seq_v, 0, 0, 1'b0);
    seq_v = mkvec(1,0,0,0,0,1,0, 64'h8000_02FC, 64'h8000_0300, 64'h8000_0100, 64'h0,
                  K_IRQ, 64'h8000_0000_0000_000B, 64'h8000_0300, 64'h8000_0100, 64'h8000_0100);
    applyStimulus("irq_next_commit", seq_v, 0, 0, 1'b0);

    $display("[TB] redirect backpressure with ignored commits");
    seq_v = mkvec(1,0,0,1,0,0,0, 64'h7000, 64'h7004, 64'h9000_0000, 64'h0,
                  K_EXC, 64'd11, 64'h7000, 64'h9000_0000, 64'h9000_0000);
    applyStimulus("backpressure5", seq_v, 0, 5, 1'b1);

    $display("[TB] reset in the middle of a redirect");
    seq_v = mkvec(1,0,0,1,0,0,0, 64'h8000, 64'h8004, 64'hA000_0000, 64'h0,
                  K_EXC, 64'd11, 64'h8000, 64'hA000_0000, 64'hA000_0000);
    driveCommit(seq_v);
    tick();
    commit_valid = 1'b0;
    tick();
    tick();
    checkOutput("pre_reset_redirect", mk(0, 0, 0, 1, 1, '0, '0, 64'hA000_0000), 64'hA000_0000);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_reset", mk(1, 0, 0, 0, 0, '0, '0, '0), '0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("post_reset_quiet", mk(1, 0, 0, 0, 0, '0, '0, '0), '0);
    end

    $display("[TB] randomized transactions");
    for (int n = 0; n < 200; n++) begin
      vec_t r;
      r.cv   = ($urandom % 8) != 0;
      r.ill  = ($urandom % 6) == 0;
      r.ebr  = ($urandom % 6) == 0;
      r.ecl  = ($urandom % 6) == 0;
      r.mrt  = ($urandom % 5) == 0;
      r.eirp = ($urandom % 3) == 0;
      r.tirp = ($urandom % 3) == 0;
      r.pc   = {$urandom, $urandom};
      r.npc  = {$urandom, $urandom};
      r.mtvec = {$urandom, $urandom};
      if ($urandom % 2 == 0) r.mtvec = (r.mtvec - (r.mtvec % 4)) + 1;
      r.mepc = {$urandom, $urandom};
      r = predict(r);
      applyStimulus($sformatf("rand%0d", n), r, int'($urandom % 4), int'($urandom % 4), 1'b1);
    end

    commit_valid = 1'b0;
    checkOutput("final_idle", mk(1, 0, 0, 0, 0, '0, '0, '0), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
